// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package     : aes_pkg
// Description : Shared types and constants for the AES-128 core sequencer.
//               ctrl_state_t - controller state encoding (2 bits)
//               NR_AES128    - round count of AES-128
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } ctrl_state_t;

    localparam int NR_AES128 = 10;

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_sched_ctrl
// Description : Job sequencer for the AES-128 core. Accepts one encrypt or
//               decrypt job at a time, drives the key expander control pins
//               and issues load/round strobes plus a round index to the
//               cipher datapath. The result is returned via valid/ready.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               in_valid/in_ready     - job offer handshake
//               in_decrypt            - job mode, sampled on acceptance
//               out_valid/out_ready   - result handshake
//               exp_reset/done1/done2 - key expander load / inverse / freeze
//               dp_load/round/last    - datapath strobes
//               dp_decrypt            - latched job mode
//               round                 - current round index 0..NR
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NR = NR_AES128,
    parameter int CW = $clog2(NR + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic          in_decrypt,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          exp_reset,
    output logic          exp_done1,
    output logic          exp_done2,
    output logic          dp_load,
    output logic          dp_round,
    output logic          dp_last,
    output logic          dp_decrypt,
    output logic [CW-1:0] round
);

    localparam logic [CW-1:0] c_nr          = CW'(NR);
    localparam logic [CW-1:0] c_expand_last = CW'(NR - 1);
    localparam logic [CW-1:0] c_one         = CW'(1);

    ctrl_state_t   r_state;
    ctrl_state_t   w_next;
    logic [CW-1:0] r_cnt;
    logic          r_decrypt;
    logic          w_accept;

    assign in_ready   = (r_state == IDLE);
    assign w_accept   = in_valid & in_ready;
    // The expander captures the key on this pulse, so it must coincide with
    // the cycle the top level presents the key (the accept cycle).
    assign exp_reset  = reset | w_accept;
    assign dp_decrypt = r_decrypt;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Shared step counter: cleared on every state change, saturates at NR.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_decrypt <= 1'b0;
        end else begin
            if (w_accept) begin
                r_decrypt <= in_decrypt;
            end
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (((r_state == EXPAND) || (r_state == ROUND)) &&
                         (r_cnt != c_nr)) begin
                r_cnt <= r_cnt + c_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = in_decrypt ? EXPAND : ROUND;
                end
            end
            EXPAND: begin
                // NR forward steps leave round key NR in the expander.
                if (r_cnt == c_expand_last) begin
                    w_next = ROUND;
                end
            end
            ROUND: begin
                if (r_cnt == c_nr) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (registered state and counter only)
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = 1'b0;
        exp_done1 = 1'b0;
        exp_done2 = 1'b0;
        dp_load   = 1'b0;
        dp_round  = 1'b0;
        dp_last   = 1'b0;
        round     = '0;
        case (r_state)
            IDLE: begin
                exp_done2 = 1'b1;
            end
            EXPAND: begin
                exp_done2 = 1'b0;
            end
            ROUND: begin
                // Inverse selection starts on the first round cycle so the
                // expander pivots from forward to inverse walk right here.
                exp_done1 = r_decrypt;
                round     = r_cnt;
                dp_load   = (r_cnt == '0);
                dp_round  = (r_cnt != '0);
                dp_last   = (r_cnt == c_nr);
            end
            DONE: begin
                out_valid = 1'b1;
                exp_done1 = r_decrypt;
                exp_done2 = 1'b1;
            end
            default: begin
                exp_done2 = 1'b1;
            end
        endcase
    end

endmodule : aes_key_sched_ctrl
`default_nettype wire

// File: tb/tb_aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_sched_ctrl
// Description : Self-checking bench for aes_key_sched_ctrl. A cycle-offset
//               reference model predicts every control output; job results
//               are tracked by a scoreboard queue popped on out_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_sched_ctrl;

    localparam int NR = 10;
    localparam int CW = $clog2(NR + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_decrypt;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic          exp_reset;
    logic          exp_done1;
    logic          exp_done2;
    logic          dp_load;
    logic          dp_round;
    logic          dp_last;
    logic          dp_decrypt;
    logic [CW-1:0] round;

    always #5 clk = ~clk;

    aes_key_sched_ctrl #(.NR(NR), .CW(CW)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_decrypt (in_decrypt),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .exp_reset  (exp_reset),
        .exp_done1  (exp_done1),
        .exp_done2  (exp_done2),
        .dp_load    (dp_load),
        .dp_round   (dp_round),
        .dp_last    (dp_last),
        .dp_decrypt (dp_decrypt),
        .round      (round)
    );

    typedef struct {
        bit dec;
        int acc_cyc;
        int lat;
    } job_t;

    job_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   chk_en = 1'b0;
    logic prev_ov = 1'b0;

    // Reference model: idle flag, job mode and cycles elapsed since accept.
    bit   m_idle = 1'b1;
    bit   m_dec  = 1'b0;
    int   m_k    = 0;

    function automatic int job_latency(bit dec);
        return dec ? (2 * NR + 2) : (NR + 2);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_idle <= 1'b1;
            m_dec  <= 1'b0;
            m_k    <= 0;
            sb_q.delete();
        end else if (m_idle) begin
            if (in_valid) begin
                m_idle <= 1'b0;
                m_k    <= 1;
                m_dec  <= in_decrypt;
                sb_q.push_back('{dec: in_decrypt, acc_cyc: cyc,
                                 lat: job_latency(in_decrypt)});
            end
        end else if ((m_k >= job_latency(m_dec)) && out_ready) begin
            m_idle <= 1'b1;
            m_k    <= 0;
        end else begin
            m_k <= m_k + 1;
        end
    end

    task automatic check_cycle();
        bit   e_done, e_exp, e_rnd;
        int   r;
        job_t j;
        e_done = !m_idle && (m_k >= job_latency(m_dec));
        e_exp  = !m_idle && m_dec && (m_k <= NR);
        e_rnd  = !m_idle && !e_done && !e_exp;
        r      = m_dec ? (m_k - NR - 1) : (m_k - 1);
        chk("in_ready",   32'(in_ready),   32'(m_idle));
        chk("exp_reset",  32'(exp_reset),  32'(reset | (m_idle & in_valid)));
        chk("out_valid",  32'(out_valid),  32'(e_done));
        chk("exp_done1",  32'(exp_done1),  32'(m_dec & (e_rnd | e_done)));
        chk("exp_done2",  32'(exp_done2),  32'(m_idle | e_done));
        chk("dp_load",    32'(dp_load),    32'(e_rnd && (r == 0)));
        chk("dp_round",   32'(dp_round),   32'(e_rnd && (r != 0)));
        chk("dp_last",    32'(dp_last),    32'(e_rnd && (r == NR)));
        chk("dp_decrypt", 32'(dp_decrypt), 32'(m_dec));
        chk("round",      32'(round),      e_rnd ? 32'(r) : 32'd0);
        // Scoreboard monitor: one pop per result presentation.
        if ((out_valid === 1'b1) && (prev_ov !== 1'b1)) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_unexpected cycle %0d: got out_valid with no job pending", cyc);
            end else begin
                j = sb_q.pop_front();
                chk("sb_latency", 32'(cyc - j.acc_cyc), 32'(j.lat));
                chk("sb_mode",    32'(dp_decrypt),      32'(j.dec));
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_cycle();
        end
        prev_ov <= out_valid;
    end

    task automatic issue(bit dec);
        int i;
        in_valid   = 1'b1;
        in_decrypt = dec;
        i = 0;
        while (!in_ready && (i < 100)) begin
            @(posedge clk); #1;
            i++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL issue_timeout cycle %0d: got in_ready=0, expected 1", cyc);
        end
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_decrypt = 1'($urandom % 2);
    endtask

    task automatic wait_ov(int limit);
        int i;
        i = 0;
        while (!out_valid && (i < limit)) begin
            @(posedge clk); #1;
            i++;
        end
        n_cmp++;
        if (!out_valid) begin
            n_fail++;
            $display("FAIL ov_timeout cycle %0d: got out_valid=0, expected 1", cyc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int i;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_decrypt = 1'b0;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Encrypt then decrypt, consumer always ready.
        issue(1'b0); wait_ov(50); @(posedge clk); #1;
        issue(1'b1); wait_ov(50); @(posedge clk); #1;

        // Backpressure, with the next job already offered while DONE.
        out_ready = 1'b0;
        issue(1'b0); wait_ov(50);
        repeat (7) begin @(posedge clk); #1; end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        issue(1'b1); wait_ov(50); @(posedge clk); #1;

        // Offer during ROUND at round 4 must be ignored.
        issue(1'b0);
        i = 0;
        while (!(dp_round && (round == CW'(4))) && (i < 30)) begin
            @(posedge clk); #1;
            i++;
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_ov(50); @(posedge clk); #1;

        // Reset at EXPAND count 6, then a clean encrypt.
        issue(1'b1);
        repeat (6) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        issue(1'b0); wait_ov(50); @(posedge clk); #1;

        // Alternating modes back-to-back.
        issue(1'b0); issue(1'b1); issue(1'b0);
        wait_ov(50); @(posedge clk); #1;

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            in_valid   = 1'($urandom % 3 != 0);
            in_decrypt = 1'($urandom % 2);
            out_ready  = 1'($urandom % 4 != 0);
            reset      = 1'($urandom % 150 == 0);
            @(posedge clk); #1;
        end
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) begin @(posedge clk); #1; end
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_aes_key_sched_ctrl
`default_nettype wire
